// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter, receiver and receive FIFO.
package uart_pkg;
   localparam int UART_DW         = 8;
   localparam int FIFO_DEPTH_DEF  = 16;
   localparam int FIFO_THRESH_DEF = 8;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word-fall-through read, sticky overrun and level interrupt.
// Write lands on rd_dat one cycle after wr_stb; writes into a full FIFO are dropped unless popped in the same cycle.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH_DEF,
   parameter int THRESH = FIFO_THRESH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_stb,
   input  logic [UART_DW-1:0]       wr_dat,
   input  logic                     rd_stb,
   input  logic                     flush,
   input  logic                     clr_ovr,
   input  logic                     irq_en,
   output logic [UART_DW-1:0]       rd_dat,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overrun,
   output logic                     irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] THRESH_L = LW'(THRESH);

   logic [UART_DW-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               do_wr;
   logic               do_rd;
   logic               ovr_set;
   logic [LW-1:0]      level_nxt;

   // A full FIFO still accepts a write when the head is popped in the same cycle.
   assign do_wr   = wr_stb & ~flush & (~full | rd_stb);
   assign do_rd   = rd_stb & ~flush & ~empty;
   assign ovr_set = wr_stb & ~flush & full & ~rd_stb;

   always_comb begin
      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else begin
         case ({do_wr, do_rd})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_nxt;
         empty <= (level_nxt == '0);
         full  <= (level_nxt == DEPTH_L);
         if (ovr_set)      overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;
      end
   end

   // Storage is deliberately left out of reset; stale entries are unreachable via the pointers.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

   assign rd_dat = empty ? '0 : mem[rd_ptr];
   assign irq    = irq_en & ((level >= THRESH_L) | overrun);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DEPTH=16, THRESH=8 with hand-computed expectations.
module tb_uart_rx_fifo;
   logic       clk = 1'b0;
   logic       rst;
   logic       wr_stb, rd_stb, flush, clr_ovr, irq_en;
   logic [7:0] wr_dat;
   logic [7:0] rd_dat;
   logic       empty, full, overrun, irq;
   logic [4:0] level;

   int vectors = 0;
   int miscompares = 0;

   uart_rx_fifo #(.DEPTH(16), .THRESH(8)) dut (
      .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_dat(wr_dat), .rd_stb(rd_stb),
      .flush(flush), .clr_ovr(clr_ovr), .irq_en(irq_en), .rd_dat(rd_dat),
      .empty(empty), .full(full), .level(level), .overrun(overrun), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_stb = 1'b1; wr_dat = b;
      tick();
      wr_stb = 1'b0;
   endtask

   task automatic pop();
      rd_stb = 1'b1;
      tick();
      rd_stb = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_stb = 1'b1; wr_dat = 8'h99; rd_stb = 1'b0;
      flush = 1'b0; clr_ovr = 1'b0; irq_en = 1'b0;
      #2;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_rd_dat", rd_dat, 8'h00);
      chk("rst_overrun", overrun, 0);
      tick();
      chk("rst_strobe_ignored", level, 0);
      wr_stb = 1'b0;
      rst = 1'b0;
      tick();

      // Basic ordering
      push(8'h41); push(8'h42); push(8'h43);
      chk("t1_level", level, 3);
      chk("t1_head", rd_dat, 8'h41);
      for (int i = 0; i < 3; i++) begin
         chk("t1_pop_data", rd_dat, 8'h41 + i);
         pop();
      end
      chk("t1_empty", empty, 1);
      chk("t1_rd_dat_zero", rd_dat, 8'h00);
      pop();
      chk("t1_pop_when_empty", level, 0);

      // Overflow drops the 17th byte
      for (int i = 0; i <= 16; i++) push(8'(i));
      chk("t2_full", full, 1);
      chk("t2_overrun", overrun, 1);
      chk("t2_level", level, 16);
      for (int i = 0; i < 16; i++) begin
         chk("t2_pop_data", rd_dat, 8'(i));
         pop();
      end
      chk("t2_empty", empty, 1);
      clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
      chk("t2_clr_ovr", overrun, 0);

      // Simultaneous push/pop while full
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      chk("t3_full", full, 1);
      wr_stb = 1'b1; wr_dat = 8'hAA; rd_stb = 1'b1;
      tick();
      wr_stb = 1'b0; rd_stb = 1'b0;
      chk("t3_level", level, 16);
      chk("t3_no_overrun", overrun, 0);
      chk("t3_head", rd_dat, 8'h11);
      for (int i = 1; i < 16; i++) pop();
      chk("t3_last_is_aa", rd_dat, 8'hAA);
      pop();
      chk("t3_drained", empty, 1);

      // Interrupt threshold and overrun priority
      irq_en = 1'b1;
      for (int i = 0; i < 7; i++) push(8'(8'h20 + i));
      chk("t4_irq_below", irq, 0);
      push(8'h27);
      chk("t4_irq_at_thresh", irq, 1);
      pop();
      chk("t4_irq_after_pop", irq, 0);
      for (int i = 0; i < 9; i++) push(8'(8'h30 + i));
      chk("t4_full", full, 1);
      wr_stb = 1'b1; wr_dat = 8'hEE; clr_ovr = 1'b1;
      tick();
      wr_stb = 1'b0; clr_ovr = 1'b0;
      chk("t4_set_beats_clr", overrun, 1);
      chk("t4_irq_ovr", irq, 1);

      // Flush
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t5_flush_level", level, 0);
      chk("t5_flush_keeps_ovr", overrun, 1);
      clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
      chk("t5_irq_clear", irq, 0);
      for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
      chk("t5_level5", level, 5);
      flush = 1'b1; wr_stb = 1'b1; wr_dat = 8'h77;
      tick();
      flush = 1'b0; wr_stb = 1'b0;
      chk("t5_flush_wr_level", level, 0);
      chk("t5_flush_wr_empty", empty, 1);
      chk("t5_flush_rd_dat", rd_dat, 8'h00);
      wr_stb = 1'b1; wr_dat = 8'h5A; rd_stb = 1'b1;
      tick();
      wr_stb = 1'b0; rd_stb = 1'b0;
      chk("t5_wr_rd_empty_level", level, 1);
      chk("t5_wr_rd_empty_data", rd_dat, 8'h5A);

      // Async reset mid-stream, checked before any clock edge
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("t6_pre_irq", irq, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_level", level, 0);
      chk("t6_async_empty", empty, 1);
      chk("t6_async_full", full, 0);
      chk("t6_async_rd_dat", rd_dat, 8'h00);
      chk("t6_async_irq", irq, 0);
      #1;
      rst = 1'b0;
      tick();
      push(8'hC3);
      chk("t6_after_rst_data", rd_dat, 8'hC3);
      chk("t6_after_rst_level", level, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
